gmii_buffer: RTL and testbench

- Store-and-forward frame buffer between a GMII-style byte receiver and a stream consumer.
- Accepts byte frames delimited by Input_valid and holds each frame until its last byte has arrived.
- Discards frames that carry an error or do not fit.
- Replays committed frames on a valid/ready/last byte stream in arrival order.

---
 rtl/gmii_buffer.sv | 119 +++++++++++
 tb/tb_gmii_buffer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_buffer.sv
// Store-and-forward byte frame buffer: speculative writes into a circular RAM,
// commit/drop at frame end, committed frames replayed on a valid/ready/last stream.
module gmii_buffer #(
  parameter int DATA_DEPTH  = 4096,
  parameter int FRAME_DEPTH = 64
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] Input_data,
  input  logic       Input_valid,
  input  logic       Input_error,
  output logic       Input_accepted,
  output logic [7:0] Output_data,
  output logic       Output_valid,
  output logic       Output_last,
  input  logic       Output_ready
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int FW = $clog2(FRAME_DEPTH);
  localparam logic [FW:0] FRM_MAX = (FW+1)'(FRAME_DEPTH);
  localparam logic [AW:0] ONE_A   = (AW+1)'(1);
  localparam logic [FW:0] ONE_F   = (FW+1)'(1);

  logic [7:0]  data_mem [DATA_DEPTH];
  logic [AW:0] len_mem  [FRAME_DEPTH];

  logic [AW:0] wr_commit, wr_spec, rd_ptr, rel_ptr, frm_len, rd_rem, occ, head_len;
  logic [FW:0] fifo_wp, fifo_rp, frm_cnt;
  logic        in_frame, frm_err, frm_ovf;
  logic        ram_full, frame_start, frame_end, wr_en, commit;
  logic        advance, fifo_empty, load_cont, load_new, xfer, xfer_last;

  // Occupancy runs from the release pointer (advanced per transfer) to the
  // speculative pointer, so rewound bytes never count and unread bytes are safe.
  assign occ         = wr_spec - rel_ptr;
  assign ram_full    = occ[AW];
  assign frame_start = Input_valid && !in_frame;
  assign frame_end   = in_frame && !Input_valid;
  assign wr_en       = Input_valid && !ram_full;
  assign commit      = frame_end && !frm_err && !frm_ovf && (frm_cnt < FRM_MAX) && (frm_len != '0);

  assign advance    = !Output_valid || Output_ready;
  assign fifo_empty = (fifo_wp == fifo_rp);
  assign load_cont  = advance && (rd_rem != '0);
  assign load_new   = advance && (rd_rem == '0) && !fifo_empty;
  assign head_len   = len_mem[fifo_rp[FW-1:0]];
  assign xfer       = Output_valid && Output_ready;
  assign xfer_last  = xfer && Output_last;

  always_ff @(posedge Clk) begin
    if (wr_en)  data_mem[wr_spec[AW-1:0]] <= Input_data;
    if (commit) len_mem[fifo_wp[FW-1:0]]  <= frm_len;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      in_frame       <= 1'b0;
      frm_err        <= 1'b0;
      frm_ovf        <= 1'b0;
      frm_len        <= '0;
      wr_spec        <= '0;
      wr_commit      <= '0;
      fifo_wp        <= '0;
      Input_accepted <= 1'b0;
    end else begin
      in_frame <= Input_valid;
      if (Input_valid) begin
        frm_err <= (frame_start ? 1'b0 : frm_err) | Input_error;
        frm_ovf <= (frame_start ? 1'b0 : frm_ovf) | ram_full;
        frm_len <= (frame_start ? '0 : frm_len) + (AW+1)'(wr_en);
        wr_spec <= wr_spec + (AW+1)'(wr_en);
      end else if (frame_end) begin
        Input_accepted <= commit;
        if (commit) begin
          wr_commit <= wr_spec;
          fifo_wp   <= fifo_wp + ONE_F;
        end else begin
          wr_spec <= wr_commit;
        end
      end
    end
  end

  // Output register stage: the frame count covers the frame being streamed,
  // so it drops only when that frame's last byte transfers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_ptr       <= '0;
      rel_ptr      <= '0;
      rd_rem       <= '0;
      fifo_rp      <= '0;
      frm_cnt      <= '0;
      Output_valid <= 1'b0;
      Output_last  <= 1'b0;
      Output_data  <= 8'd0;
    end else begin
      if (xfer) rel_ptr <= rel_ptr + ONE_A;
      frm_cnt <= frm_cnt + (FW+1)'(commit) - (FW+1)'(xfer_last);
      if (load_cont || load_new) begin
        Output_valid <= 1'b1;
        Output_data  <= data_mem[rd_ptr[AW-1:0]];
        rd_ptr       <= rd_ptr + ONE_A;
        if (load_new) begin
          fifo_rp     <= fifo_rp + ONE_F;
          rd_rem      <= head_len - ONE_A;
          Output_last <= (head_len == ONE_A);
        end else begin
          rd_rem      <= rd_rem - ONE_A;
          Output_last <= (rd_rem == ONE_A);
        end
      end else if (advance) begin
        Output_valid <= 1'b0;
        Output_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gmii_buffer.sv
// Randomized scoreboard bench for gmii_buffer: expected beats and accept flags are
// queued at stimulus time and checked by independent monitor processes.
module tb_gmii_buffer;

  localparam int DD = 4096;
  localparam int FD = 64;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [7:0] Input_data = 8'd0;
  logic       Input_valid = 1'b0;
  logic       Input_error = 1'b0;
  logic       Input_accepted;
  logic [7:0] Output_data;
  logic       Output_valid;
  logic       Output_last;
  logic       Output_ready = 1'b0;

  gmii_buffer #(.DATA_DEPTH(DD), .FRAME_DEPTH(FD)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Input_data(Input_data), .Input_valid(Input_valid), .Input_error(Input_error),
    .Input_accepted(Input_accepted),
    .Output_data(Output_data), .Output_valid(Output_valid), .Output_last(Output_last),
    .Output_ready(Output_ready)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [7:0] d; logic l; } beat_t;
  typedef struct { logic v; longint due; } acc_t;

  beat_t  exp_q[$];
  acc_t   acc_q[$];
  longint cyc = 0;
  int     checks = 0, errors = 0;
  int     ready_pct = 100;
  int     out_bytes = 0, out_frames = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Consumer: randomizes ready, compares each transfer with the scoreboard head.
  initial begin : monitor
    logic       held = 1'b0;
    logic [7:0] hd = 8'd0;
    logic       hl = 1'b0;
    logic       r;
    beat_t      b;
    forever begin
      @(negedge Clk);
      r = ($urandom_range(99) < ready_pct);
      Output_ready = r;
      if (Rst_n && Output_valid) begin
        if (held) begin
          chk("hold_data", Output_data, hd);
          chk("hold_last", Output_last, hl);
        end
        if (r) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            b = exp_q.pop_front();
            chk("out_data", Output_data, b.d);
            chk("out_last", Output_last, b.l);
            out_bytes--;
            if (b.l) out_frames--;
          end
        end else begin
          held = 1'b1;
          hd = Output_data;
          hl = Output_last;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin : acc_checker
    acc_t a;
    forever begin
      @(negedge Clk);
      if (Rst_n && acc_q.size() > 0 && acc_q[0].due == cyc) begin
        a = acc_q.pop_front();
        chk("input_accepted", Input_accepted, a.v);
      end
    end
  end

  // A frame commits iff it is clean and the buffer still has frame and byte room.
  task automatic send_frame(input int len, input int errpos, input int gap,
                            input bit fixed, input logic [7:0] fill);
    logic [7:0] bytes[$];
    logic       pred;
    acc_t       a;
    for (int i = 0; i < len; i++) bytes.push_back(fixed ? fill : 8'($urandom));
    pred = (errpos < 0) && (out_frames < FD) && (out_bytes + len <= DD);
    if (pred) begin
      out_bytes  += len;
      out_frames += 1;
      for (int i = 0; i < len; i++) exp_q.push_back('{d: bytes[i], l: (i == len - 1)});
    end
    for (int i = 0; i < len; i++) begin
      @(negedge Clk);
      Input_valid = 1'b1;
      Input_data  = bytes[i];
      Input_error = (i == errpos);
    end
    @(negedge Clk);
    Input_valid = 1'b0;
    Input_error = 1'b0;
    Input_data  = 8'd0;
    a.v = pred;
    a.due = cyc + 2;
    acc_q.push_back(a);
    repeat (gap - 1) @(negedge Clk);
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || acc_q.size() != 0) && n < limit) begin
      @(negedge Clk);
      n++;
    end
    if (n >= limit) chk("drain_timeout", exp_q.size(), 0);
    repeat (5) @(negedge Clk);
  endtask

  task automatic wait_room(input int len);
    int n = 0;
    while ((out_bytes + len > DD || out_frames >= FD) && n < 40000) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 40000) chk("room_timeout", out_bytes, 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_valid", Output_valid, 0);
    chk("rst_last", Output_last, 0);
    chk("rst_data", Output_data, 0);
    chk("rst_accepted", Input_accepted, 0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #1;
    Rst_n = 1'b0;
    Input_valid = 1'b0;
    Input_error = 1'b0;
    exp_q.delete();
    acc_q.delete();
    out_bytes = 0;
    out_frames = 0;
    #1;
    check_reset_outputs();
    repeat (10) @(negedge Clk);
    check_reset_outputs();
    Rst_n = 1'b1;
  endtask

  task automatic random_phase(input int pct, input int nfr, input int maxlen);
    int len, ep;
    ready_pct = pct;
    for (int f = 0; f < nfr; f++) begin
      len = $urandom_range(maxlen, 1);
      ep  = ($urandom_range(99) < 5) ? int'($urandom_range(len - 1)) : -1;
      if (ep < 0) wait_room(len);
      send_frame(len, ep, $urandom_range(200, 1), 1'b0, 8'd0);
    end
    wait_drain(40000);
  endtask

  initial begin
    Rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    ready_pct = 100;
    send_frame(1, -1, 5, 1'b1, 8'hA5);
    wait_drain(100);

    send_frame(10, 0, 4, 1'b0, 8'd0);
    send_frame(10, 9, 4, 1'b0, 8'd0);
    send_frame(10, 5, 1, 1'b0, 8'd0);
    send_frame(10, -1, 3, 1'b0, 8'd0);
    wait_drain(200);

    random_phase(80, 20, 1500);
    random_phase(10, 10, 150);

    ready_pct = 0;
    for (int f = 0; f < FD + 1; f++) send_frame(1, -1, 1, 1'b0, 8'd0);
    repeat (5) @(negedge Clk);
    ready_pct = 100;
    wait_drain(1000);
    repeat (20) @(negedge Clk);

    ready_pct = 0;
    for (int f = 0; f < 3; f++) send_frame(1500, -1, 2, 1'b0, 8'd0);
    repeat (5) @(negedge Clk);
    ready_pct = 100;
    wait_drain(5000);
    send_frame(1500, -1, 2, 1'b0, 8'd0);
    wait_drain(5000);

    ready_pct = 0;
    send_frame(300, -1, 2, 1'b0, 8'd0);
    send_frame(200, -1, 2, 1'b0, 8'd0);
    ready_pct = 100;
    repeat (40) @(negedge Clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      Input_valid = 1'b1;
      Input_data  = 8'($urandom);
    end
    do_reset();
    repeat (20) @(negedge Clk);
    chk("no_stale_valid", Output_valid, 0);
    send_frame(50, -1, 3, 1'b0, 8'd0);
    wait_drain(500);

    chk("exp_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
